lbuf3_sched: RTL and testbench

Bank scheduler for the three-line 3x3 filter buffer. It tracks the incoming video raster (`vvalid`/`hvalid`) and drives the write enables and write address of three single-line RAM banks. It also drives the read rotation selects, so the filter always sees rows top/mid/bottom in order. It emits the row/column border flags the Sobel/Canny kernels need, and after the last input line it generates one synthetic flush line so the final output row is produced.

---
 rtl/lbuf3_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_lbuf3_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbuf3_sched.sv
// lbuf3_sched: bank write/rotation scheduler and border-flag generator for a three-line 3x3 filter buffer.
// Optional synthetic flush line after the last input line: define LBUF3_SCHED_FLUSH_EN.
module lbuf3_sched #(
    parameter int H_ACT     = 1920,
    parameter int V_ACT     = 1080,
    parameter int AW        = 11,
    parameter int FLUSH_GAP = 280
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          vvalid,
    input  logic          hvalid,
    output logic [2:0]    wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [1:0]    top_sel,
    output logic [1:0]    mid_sel,
    output logic          rd_valid,
    output logic [AW-1:0] row_cnt,
    output logic          first_row,
    output logic          last_row,
    output logic          first_col,
    output logic          last_col,
    output logic          fsync,
    output logic          len_err,
    output logic          frm_err
);

    localparam logic [AW-1:0] H_FULL = AW'(H_ACT);
    localparam logic [AW-1:0] H_LAST = AW'(H_ACT - 1);
    localparam logic [AW-1:0] V_FULL = AW'(V_ACT);
`ifdef LBUF3_SCHED_FLUSH_EN
    localparam logic [AW-1:0] V_LAST = AW'(V_ACT - 1);
    localparam int            GW     = $clog2(FLUSH_GAP + 1);
    localparam logic [GW-1:0] G_LAST = GW'(FLUSH_GAP - 1);
`endif

    if ((1 << AW) <= H_ACT || (1 << AW) <= V_ACT + 1 || FLUSH_GAP < 1) begin : g_bad_cfg
        $error("lbuf3_sched: AW too narrow for H_ACT/V_ACT, or FLUSH_GAP < 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LINE,
        S_END
`ifdef LBUF3_SCHED_FLUSH_EN
        , S_GAP,
        S_FLUSH
`endif
    } state_t;

    state_t        state, state_n;
    logic          vvalid_q, hvalid_q, vvalid_d, hvalid_d;
    logic [AW-1:0] col, col_n, lines, lines_n, px_col, row_n;
    logic [1:0]    wbank, wbank_n;
    logic          fs_act, fs_act_n, len_err_n, frm_err_n;
    logic          px, flush_px, rd, v_rise, h_rise;
`ifdef LBUF3_SCHED_FLUSH_EN
    logic [GW-1:0] gcnt, gcnt_n;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    assign v_rise = vvalid_q && !vvalid_d;
    assign h_rise = hvalid_q && !hvalid_d;

    always_comb begin
        state_n   = state;
        col_n     = col;
        lines_n   = lines;
        wbank_n   = wbank;
        fs_act_n  = fs_act;
        len_err_n = len_err;
        frm_err_n = frm_err;
        px        = 1'b0;
        flush_px  = 1'b0;
        px_col    = col;
`ifdef LBUF3_SCHED_FLUSH_EN
        gcnt_n    = gcnt;
`endif
        case (state)
            S_IDLE: begin
                if (v_rise) begin
                    state_n   = S_WAIT;
                    len_err_n = 1'b0;
                    frm_err_n = 1'b0;
                    lines_n   = '0;
                    wbank_n   = 2'd0;
                    col_n     = '0;
                    fs_act_n  = 1'b0;
                end
            end
            S_WAIT: begin
                if (!vvalid_q) begin
                    state_n = S_END;
                end else if (h_rise) begin
                    // The rising-edge cycle already carries pixel 0.
                    state_n = S_LINE;
                    px      = 1'b1;
                    px_col  = '0;
                    col_n   = AW'(1);
                    if (lines != '0) fs_act_n = 1'b1;
                end
            end
            S_LINE: begin
                if (hvalid_q && vvalid_q) begin
                    if (col < H_FULL) begin
                        px    = 1'b1;
                        col_n = col + 1'b1;
                        if (lines != '0) fs_act_n = 1'b1;
                    end else begin
                        len_err_n = 1'b1;
                    end
                end else begin
                    // A vvalid drop with hvalid still high truncates the line.
                    if (col != H_FULL || hvalid_q) len_err_n = 1'b1;
                    wbank_n = inc3(wbank);
                    if (lines <= V_FULL) lines_n = lines + 1'b1;
`ifndef LBUF3_SCHED_FLUSH_EN
                    if (lines + 1'b1 >= V_FULL) fs_act_n = 1'b0;
`endif
                    state_n = vvalid_q ? S_WAIT : S_END;
                end
            end
            S_END: begin
                if (lines != V_FULL) frm_err_n = 1'b1;
                col_n = '0;
`ifdef LBUF3_SCHED_FLUSH_EN
                gcnt_n = '0;
                if (lines < AW'(2)) begin
                    state_n  = S_IDLE;
                    fs_act_n = 1'b0;
                end else begin
                    state_n = S_GAP;
                end
`else
                state_n  = S_IDLE;
                fs_act_n = 1'b0;
`endif
            end
`ifdef LBUF3_SCHED_FLUSH_EN
            S_GAP: begin
                gcnt_n = gcnt + 1'b1;
                if (gcnt == G_LAST) state_n = S_FLUSH;
            end
            S_FLUSH: begin
                flush_px = 1'b1;
                col_n    = col + 1'b1;
                if (col == H_LAST) begin
                    state_n  = S_IDLE;
                    fs_act_n = 1'b0;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        rd = (px && lines != '0) || flush_px;
`ifdef LBUF3_SCHED_FLUSH_EN
        row_n = flush_px ? V_LAST : lines - 1'b1;
`else
        row_n = lines - 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            // vvalid starts as seen high so a frame already running at reset release is not a fresh rise.
            vvalid_q  <= 1'b1;
            vvalid_d  <= 1'b1;
            hvalid_q  <= 1'b0;
            hvalid_d  <= 1'b0;
            state     <= S_IDLE;
            col       <= '0;
            lines     <= '0;
            wbank     <= 2'd0;
            fs_act    <= 1'b0;
            len_err   <= 1'b0;
            frm_err   <= 1'b0;
`ifdef LBUF3_SCHED_FLUSH_EN
            gcnt      <= '0;
`endif
            wr_en     <= 3'b000;
            wr_addr   <= '0;
            rd_valid  <= 1'b0;
            row_cnt   <= '0;
            first_row <= 1'b0;
            last_row  <= 1'b0;
            first_col <= 1'b0;
            last_col  <= 1'b0;
            fsync     <= 1'b0;
            top_sel   <= 2'd1;
            mid_sel   <= 2'd2;
        end else begin
            vvalid_q  <= vvalid;
            vvalid_d  <= vvalid_q;
            hvalid_q  <= hvalid && vvalid;
            hvalid_d  <= hvalid_q;
            state     <= state_n;
            col       <= col_n;
            lines     <= lines_n;
            wbank     <= wbank_n;
            fs_act    <= fs_act_n;
            len_err   <= len_err_n;
            frm_err   <= frm_err_n;
`ifdef LBUF3_SCHED_FLUSH_EN
            gcnt      <= gcnt_n;
`endif
            wr_en     <= px ? 3'(3'b001 << wbank) : 3'b000;
            wr_addr   <= (px || flush_px) ? px_col : '0;
            rd_valid  <= rd;
            row_cnt   <= rd ? row_n : '0;
            first_row <= rd && (row_n == '0);
            last_row  <= flush_px;
            first_col <= rd && (px_col == '0);
            last_col  <= rd && (px_col == H_LAST);
            fsync     <= fs_act_n || rd;
            top_sel   <= inc3(wbank_n);
            mid_sel   <= inc3(inc3(wbank_n));
        end
    end

endmodule

// File: tb/tb_lbuf3_sched.sv
// Directed bench for lbuf3_sched with H_ACT=8, V_ACT=4, FLUSH_GAP=3.
// Expected values follow LBUF3_SCHED_FLUSH_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_lbuf3_sched;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int G  = 3;
    localparam int AW = 4;
`ifdef LBUF3_SCHED_FLUSH_EN
    localparam int FL    = 1;
    localparam int LOG_W = 28;
    localparam logic [LOG_W-1:0] LOG_EXP = {7'b0001000, 7'b0010001, 7'b0100110, 7'b0111000};
`else
    localparam int FL    = 0;
    localparam int LOG_W = 21;
    localparam logic [LOG_W-1:0] LOG_EXP = {7'b0001000, 7'b0010001, 7'b0100110};
`endif

    logic          clk = 1'b0;
    logic          rst_b, vvalid, hvalid;
    logic [2:0]    wr_en;
    logic [AW-1:0] wr_addr, row_cnt;
    logic [1:0]    top_sel, mid_sel;
    logic          rd_valid, first_row, last_row, first_col, last_col, fsync, len_err, frm_err;

    int total = 0;
    int bad   = 0;

    lbuf3_sched #(.H_ACT(H), .V_ACT(V), .AW(AW), .FLUSH_GAP(G)) dut (
        .clk(clk), .rst_b(rst_b), .vvalid(vvalid), .hvalid(hvalid),
        .wr_en(wr_en), .wr_addr(wr_addr), .top_sel(top_sel), .mid_sel(mid_sel),
        .rd_valid(rd_valid), .row_cnt(row_cnt), .first_row(first_row), .last_row(last_row),
        .first_col(first_col), .last_col(last_col), .fsync(fsync),
        .len_err(len_err), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // Output monitor: accumulates counts and a per-output-line log.
    int            tick = 0, n_rd = 0, n_we = 0, n_fc = 0, n_lc = 0, n_fr = 0, n_lr = 0;
    int            n_addr_bad = 0, n_flag_bad = 0, n_fs_bad = 0, t_last_rd = 0, t_fs_fall = 0;
    logic [2:0]    prev_we = 3'b000;
    logic          prev_act = 1'b0, fs_prev = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [11:0]   we_seq = '0;
    logic [27:0]   lg = '0;
    logic          act;

    assign act = (wr_en != 3'b000) || rd_valid;

    always @(negedge clk) begin
        tick      <= tick + 1;
        prev_we   <= wr_en;
        prev_act  <= act;
        prev_addr <= wr_addr;
        fs_prev   <= fsync;
        if (wr_en != 3'b000) n_we <= n_we + 1;
        if (wr_en != 3'b000 && prev_we == 3'b000) we_seq <= {we_seq[8:0], wr_en};
        if (rd_valid) begin
            n_rd      <= n_rd + 1;
            t_last_rd <= tick;
            if (!fsync) n_fs_bad <= n_fs_bad + 1;
        end
        if (rd_valid && first_col) lg <= {lg[20:0], row_cnt[2:0], top_sel, mid_sel};
        if (first_col) n_fc <= n_fc + 1;
        if (last_col)  n_lc <= n_lc + 1;
        if (first_row) n_fr <= n_fr + 1;
        if (last_row)  n_lr <= n_lr + 1;
        if (act && int'(wr_addr) != (prev_act ? int'(prev_addr) + 1 : 0)) n_addr_bad <= n_addr_bad + 1;
        if ((first_col !== (rd_valid && wr_addr == 4'd0)) ||
            (last_col  !== (rd_valid && wr_addr == 4'd7)) ||
            (first_row !== (rd_valid && row_cnt == 4'd0))) n_flag_bad <= n_flag_bad + 1;
        if (fs_prev && !fsync) t_fs_fall <= tick;
    end

    int b_rd, b_we, b_fc, b_lc, b_fr, b_lr, b_ab, b_fb, b_fs;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rd = n_rd; b_we = n_we; b_fc = n_fc; b_lc = n_lc; b_fr = n_fr;
        b_lr = n_lr; b_ab = n_addr_bad; b_fb = n_flag_bad; b_fs = n_fs_bad;
    endtask

    task automatic drive_line(input int n);
        hvalid = 1'b1;
        cyc(n);
        hvalid = 1'b0;
        cyc(4);
    endtask

    task automatic nominal(input string p);
        snap();
        vvalid = 1'b1;
        cyc(3);
        chk({p, "_len_clr"}, int'(len_err), 0);
        chk({p, "_frm_clr"}, int'(frm_err), 0);
        hvalid = 1'b1;
        cyc(1);
        chk({p, "_lat1_we"}, int'(wr_en), 0);
        cyc(1);
        chk({p, "_lat2_we"}, int'(wr_en), 1);
        chk({p, "_lat2_addr"}, int'(wr_addr), 0);
        chk({p, "_l0_rd"}, int'(rd_valid), 0);
        cyc(6);
        hvalid = 1'b0;
        cyc(4);
        drive_line(8);
        drive_line(8);
        hvalid = 1'b1;
        cyc(5);
        chk({p, "_l3_we"}, int'(wr_en), 1);
        chk({p, "_l3_addr"}, int'(wr_addr), 3);
        chk({p, "_l3_top"}, int'(top_sel), 1);
        chk({p, "_l3_mid"}, int'(mid_sel), 2);
        chk({p, "_l3_row"}, int'(row_cnt), 2);
        chk({p, "_l3_rd"}, int'(rd_valid), 1);
        chk({p, "_l3_fsync"}, int'(fsync), 1);
        cyc(3);
        hvalid = 1'b0;
        cyc(4);
        vvalid = 1'b0;
        cyc(20);
        chk({p, "_rd_cnt"}, n_rd - b_rd, 24 + 8 * FL);
        chk({p, "_we_cnt"}, n_we - b_we, 32);
        chk({p, "_we_seq"}, int'(we_seq), int'(12'b001_010_100_001));
        chk({p, "_line_log"}, int'(lg[LOG_W-1:0]), int'(LOG_EXP));
        chk({p, "_first_col"}, n_fc - b_fc, 3 + FL);
        chk({p, "_last_col"}, n_lc - b_lc, 3 + FL);
        chk({p, "_first_row"}, n_fr - b_fr, 8);
        chk({p, "_last_row"}, n_lr - b_lr, 8 * FL);
        chk({p, "_addr_seq"}, n_addr_bad - b_ab, 0);
        chk({p, "_flags"}, n_flag_bad - b_fb, 0);
        chk({p, "_fs_cover"}, n_fs_bad - b_fs, 0);
        chk({p, "_fs_fall"}, t_fs_fall - t_last_rd, 1);
        chk({p, "_len_err"}, int'(len_err), 0);
        chk({p, "_frm_err"}, int'(frm_err), 0);
        chk({p, "_fsync_end"}, int'(fsync), 0);
    endtask

    initial begin
        rst_b  = 1'b0;
        vvalid = 1'b0;
        hvalid = 1'b0;
        cyc(3);
        chk("rst_we", int'(wr_en), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_top", int'(top_sel), 1);
        chk("rst_mid", int'(mid_sel), 2);
        chk("rst_rd", int'(rd_valid), 0);
        chk("rst_row", int'(row_cnt), 0);
        chk("rst_fsync", int'(fsync), 0);
        chk("rst_len", int'(len_err), 0);
        chk("rst_frm", int'(frm_err), 0);
        rst_b = 1'b1;
        cyc(3);

        nominal("nom");

        // Over-long first line: only H writes, len_err sticky.
        snap();
        vvalid = 1'b1;
        cyc(3);
        drive_line(10);
        chk("long_we_l0", n_we - b_we, 8);
        chk("long_len_err", int'(len_err), 1);
        drive_line(8);
        drive_line(8);
        drive_line(8);
        vvalid = 1'b0;
        cyc(20);
        chk("long_we", n_we - b_we, 32);
        chk("long_rd", n_rd - b_rd, 24 + 8 * FL);
        chk("long_frm", int'(frm_err), 0);
        chk("long_len_keep", int'(len_err), 1);

        // Short first line: len_err set, next line restarts at column 0.
        snap();
        vvalid = 1'b1;
        cyc(3);
        chk("short_len_clr", int'(len_err), 0);
        drive_line(6);
        chk("short_len_err", int'(len_err), 1);
        chk("short_we_l0", n_we - b_we, 6);
        drive_line(8);
        drive_line(8);
        drive_line(8);
        vvalid = 1'b0;
        cyc(20);
        chk("short_rd", n_rd - b_rd, 24 + 8 * FL);
        chk("short_addr_seq", n_addr_bad - b_ab, 0);
        chk("short_first_col", n_fc - b_fc, 3 + FL);

        // One-line frame: no output rows.
        snap();
        vvalid = 1'b1;
        cyc(3);
        drive_line(8);
        vvalid = 1'b0;
        cyc(20);
        chk("one_rd", n_rd - b_rd, 0);
        chk("one_we", n_we - b_we, 8);
        chk("one_frm", int'(frm_err), 1);
        chk("one_fsync", int'(fsync), 0);

        // Five-line frame.
        snap();
        vvalid = 1'b1;
        cyc(3);
        chk("five_frm_clr", int'(frm_err), 0);
        for (int i = 0; i < 5; i++) drive_line(8);
        vvalid = 1'b0;
        cyc(20);
        chk("five_frm", int'(frm_err), 1);
        chk("five_len", int'(len_err), 0);
        chk("five_rd", n_rd - b_rd, 32 + 8 * FL);

        // Asynchronous reset in the middle of line 2.
        vvalid = 1'b1;
        cyc(3);
        drive_line(8);
        drive_line(8);
        hvalid = 1'b1;
        cyc(5);
        chk("pre_rst_we", int'(wr_en), 4);
        rst_b = 1'b0;
        #1;
        chk("arst_we", int'(wr_en), 0);
        chk("arst_addr", int'(wr_addr), 0);
        chk("arst_rd", int'(rd_valid), 0);
        chk("arst_row", int'(row_cnt), 0);
        chk("arst_top", int'(top_sel), 1);
        chk("arst_mid", int'(mid_sel), 2);
        chk("arst_fsync", int'(fsync), 0);
        hvalid = 1'b0;
        vvalid = 1'b0;
        cyc(3);
        rst_b = 1'b1;
        cyc(3);

        nominal("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
